// File: rtl/booth_skip_datapath.sv
// booth_skip_datapath: datapath and sequencer for a 4x4 unsigned run-skipping
// multiplier. Operands are taken over a start/ready handshake. The live
// multiplier window is shown to an external run-skipping control unit, whose
// per-step outputs steer shifting of the window and add/subtract of shifted
// multiplicands into a 9-bit two's-complement accumulator.
//
// Ports
//   clk            in   clock, rising edge
//   rstN           in   asynchronous active-low reset
//   start          in   request, accepted only while ready=1
//   a_in[3:0]      in   multiplicand (unsigned)
//   b_in[3:0]      in   multiplier (unsigned)
//   ready          out  idle, can accept start
//   product[7:0]   out  last result, held until next completion
//   product_valid  out  one-cycle pulse when product updates
//   cu_b[3:0]      out  current multiplier window for the control unit
//   cu_rstN        out  registered active-low clear for the control unit
//   A_shift_amount in   absolute multiplicand shift for this step
//   B_shift_amount in   window shift for this step
//   op             in   0 = skip zeros (subtract), 1 = skip ones (add)
//   done           in   this step reaches past bit 3
module booth_skip_datapath (
  input  logic       clk,
  input  logic       rstN,
  input  logic       start,
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  output logic       ready,
  output logic [7:0] product,
  output logic       product_valid,
  output logic [3:0] cu_b,
  output logic       cu_rstN,
  input  logic [2:0] A_shift_amount,
  input  logic [2:0] B_shift_amount,
  input  logic       op,
  input  logic       done
);

  localparam int unsigned OP_W   = 4;
  localparam int unsigned PROD_W = 8;
  localparam int unsigned ACC_W  = 9;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [OP_W-1:0]   a_q, a_d;
  logic [OP_W-1:0]   b_q, b_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  addend_c;
  logic              complete_c;

  logic [PROD_W-1:0] product_q, product_d;
  logic              product_valid_q, product_valid_d;
  logic              ready_q, ready_d;
  logic              cu_rstn_q, cu_rstn_d;

  // Per-step datapath decode; rules are checked in priority order.
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    addend_c   = '0;
    complete_c = 1'b0;
    if (state_q == S_IDLE) begin
      if (start) begin
        a_d   = a_in;
        b_d   = b_in;
        acc_d = '0;
      end
    end else begin
      if (!op && (b_q == '0)) begin
        // Nothing left to skip: finish without accumulating.
        complete_c = 1'b1;
      end else if (op && (b_q == 4'b1111)) begin
        // Whole window is ones: close the run at bit 4 directly.
        addend_c   = ACC_W'(a_q) << 4;
        acc_d      = acc_q + addend_c;
        complete_c = 1'b1;
      end else if (op) begin
        addend_c   = ACC_W'(a_q) << A_shift_amount;
        acc_d      = acc_q + addend_c;
        b_d        = b_q >> B_shift_amount;
        complete_c = done;
      end else if (done) begin
        complete_c = 1'b1;
      end else begin
        addend_c = ACC_W'(a_q) << A_shift_amount;
        acc_d    = acc_q - addend_c;
        b_d      = b_q >> B_shift_amount;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)      state_d = S_RUN;
      S_RUN:   if (complete_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output next values; control unit is released exactly while in RUN.
  always_comb begin
    ready_d         = (state_d == S_IDLE);
    cu_rstn_d       = (state_d == S_RUN);
    product_valid_d = complete_c;
    product_d       = product_q;
    if (complete_c) product_d = acc_d[PROD_W-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      a_q             <= '0;
      b_q             <= '0;
      acc_q           <= '0;
      product_q       <= '0;
      product_valid_q <= 1'b0;
      ready_q         <= 1'b1;
      cu_rstn_q       <= 1'b0;
    end else begin
      a_q             <= a_d;
      b_q             <= b_d;
      acc_q           <= acc_d;
      product_q       <= product_d;
      product_valid_q <= product_valid_d;
      ready_q         <= ready_d;
      cu_rstn_q       <= cu_rstn_d;
    end
  end

  assign ready         = ready_q;
  assign product       = product_q;
  assign product_valid = product_valid_q;
  assign cu_b          = b_q;
  assign cu_rstN       = cu_rstn_q;

endmodule

// File: tb/tb_booth_skip_datapath.sv
// Bench for booth_skip_datapath: contains a behavioural run-skipping control
// unit, a product scoreboard (a*b plus expected completion cycle) and directed
// plus random operand pairs, including mid-run reset and back-to-back starts.
module tb_booth_skip_datapath;

  logic       clk = 1'b0;
  logic       rstN;
  logic       start;
  logic [3:0] a_in, b_in;
  logic       ready;
  logic [7:0] product;
  logic       product_valid;
  logic [3:0] cu_b;
  logic       cu_rstN;
  logic [2:0] A_shift_amount, B_shift_amount;
  logic       op, done;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  typedef struct {
    logic [7:0] prod;
    int         cyc;
  } exp_t;
  exp_t sb_q[$];

  booth_skip_datapath dut (
    .clk            (clk),
    .rstN           (rstN),
    .start          (start),
    .a_in           (a_in),
    .b_in           (b_in),
    .ready          (ready),
    .product        (product),
    .product_valid  (product_valid),
    .cu_b           (cu_b),
    .cu_rstN        (cu_rstN),
    .A_shift_amount (A_shift_amount),
    .B_shift_amount (B_shift_amount),
    .op             (op),
    .done           (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Control unit: alternates skip-zeros / skip-ones, first step skips zeros.
  logic [2:0] cu_pos_q;
  logic       cu_op_q;
  int         run_len;
  logic       stop;

  always @(posedge clk or negedge cu_rstN) begin
    if (!cu_rstN) begin
      cu_pos_q <= 3'd0;
      cu_op_q  <= 1'b0;
    end else begin
      cu_pos_q <= cu_pos_q + B_shift_amount;
      cu_op_q  <= ~cu_op_q;
    end
  end

  always_comb begin
    run_len = 0;
    stop    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!stop && (cu_b[i] == cu_op_q)) run_len++;
      else stop = 1'b1;
    end
    op             = cu_op_q;
    B_shift_amount = 3'(run_len);
    A_shift_amount = 3'(int'(cu_pos_q) + run_len);
    done           = (int'(cu_pos_q) + run_len) > 3;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (product_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("product", int'(product), int'(e.prod));
        if (e.cyc >= 0) check("latency", cyc, e.cyc);
      end
    end
  end

  // Issue one multiply; n<0 skips the latency check.
  task automatic do_op(input int a, input int b, input int n,
                       input bit poke, input bit b2b);
    int w;
    w = 0;
    while (!ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (!ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    if (b2b) check("b2b_valid_cycle", int'(product_valid), 1);
    a_in  = 4'(a);
    b_in  = 4'(b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sb_q.push_back('{8'(a * b), (n < 0) ? -1 : cyc + n});
    if (poke) begin
      // start during RUN must be ignored
      @(posedge clk); #1;
      start = 1'b1; a_in = 4'd1; b_in = 4'd1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 40) begin
      @(posedge clk); #1; w++;
    end
    check("drain", sb_q.size(), 0);
  endtask

  initial begin
    rstN  = 1'b0;
    start = 1'b0;
    a_in  = 4'd0;
    b_in  = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", int'(ready), 1);
    check("rst_product", int'(product), 0);
    check("rst_valid", int'(product_valid), 0);
    check("rst_cu_rstN", int'(cu_rstN), 0);
    check("rst_cu_b", int'(cu_b), 0);
    rstN = 1'b1;
    @(posedge clk); #1;

    do_op(7, 5, 5, 1'b0, 1'b0);
    drain();

    // Reset during the second RUN cycle of A=15, B=5.
    a_in = 4'd15; b_in = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("mid_run_ready", int'(ready), 0);
    check("mid_run_cu_rstN", int'(cu_rstN), 1);
    rstN = 1'b0;
    #1;
    check("abort_product", int'(product), 0);
    check("abort_valid", int'(product_valid), 0);
    check("abort_ready", int'(ready), 1);
    check("abort_cu_rstN", int'(cu_rstN), 0);
    @(posedge clk); #1;
    check("abort_hold_product", int'(product), 0);
    check("abort_hold_cu_rstN", int'(cu_rstN), 0);
    rstN = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("after_abort_ready", int'(ready), 1);
    check("after_abort_product", int'(product), 0);

    do_op(9, 0, 1, 1'b0, 1'b0);
    do_op(15, 15, 2, 1'b0, 1'b0);
    do_op(13, 8, 2, 1'b1, 1'b0);
    drain();
    do_op(3, 6, 3, 1'b0, 1'b0);
    do_op(0, 15, 2, 1'b0, 1'b1);
    drain();

    for (int i = 0; i < 12; i++) begin
      do_op(int'($urandom_range(15)), int'($urandom_range(15)), -1, 1'b0, 1'b0);
    end
    drain();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/booth_skip_datapath.md
# booth_skip_datapath

Datapath and sequencer for the 4×4 unsigned run-skipping multiplier. Accepts operands over a start/ready handshake, presents the live multiplier window to the run-skipping control unit, and consumes its per-step outputs (`op`, shift amounts, `done`) to shift the window and add/subtract shifted multiplicands. Each run of ones in B costs one subtract and one add, each run of zeros costs one shift. Ends with a registered 8-bit product and a one-cycle valid pulse.

## Interface
- No parameters; operand width fixed at 4, product at 8.
- `clk`  in  1  single clock, rising edge
- `rstN`  in  1  asynchronous, active-low reset
- `start`  in  1  request; accepted only when `ready`=1
- `a_in`  in  4  multiplicand, unsigned
- `b_in`  in  4  multiplier, unsigned
- `ready`  out  1  idle, can accept `start`
- `product`  out  8  last result, held until next completion
- `product_valid`  out  1  one-cycle pulse when `product` updates
- `cu_b`  out  4  multiplier window to control unit (= `b_reg`)
- `cu_rstN`  out  1  registered active-low clear for control unit
- `A_shift_amount`  in  3  from control: absolute multiplicand shift this step
- `B_shift_amount`  in  3  from control: window shift this step
- `op`  in  1  from control: 0 = skip zeros / land on run start, 1 = skip ones / land on run end
- `done`  in  1  from control: this step reaches past bit 3

## Operation
- Registers: `a_reg`[3:0], `b_reg`[3:0], `acc`[8:0] two's complement, state {IDLE, RUN}, `product`, `product_valid`, `cu_rstN`.
- IDLE: `ready`=1, `cu_rstN`=0 (control unit held cleared). On `start`: `a_reg`<=`a_in`, `b_reg`<=`b_in`, `acc`<=0, `cu_rstN`<=1, state<=RUN.
- RUN, once per cycle, in priority order:
  - Terminate-empty: `op`=0 and `b_reg`=0. No accumulate. Complete.
  - Full-window: `op`=1 and `b_reg`=4'b1111. `acc`+=`a_reg`<<4. Complete. Do not use control shift values.
  - `op`=1: `acc`+=`a_reg`<<`A_shift_amount`. `b_reg`<=`b_reg`>>`B_shift_amount`, logical, zero fill. Complete if `done`.
  - `op`=0: if `done`, complete with no accumulate. Otherwise `acc`-=`a_reg`<<`A_shift_amount` and `b_reg`<=`b_reg`>>`B_shift_amount`.
- Complete, on the same edge: `product`<=`acc_next`[7:0], `product_valid`<=1, `cu_rstN`<=0, state<=IDLE.
- Arithmetic:
  - `acc` is 9-bit signed. Shifted multiplicand is zero-extended to 9 bits before add/sub.
  - Intermediate range is −120..255; the final value is always 0..225.
  - A shift of ≥4 applied to `b_reg` yields 0.
- `start` while in RUN is ignored; no queueing.

## Timing
- Reset values: `ready`=1, `product`=0, `product_valid`=0, `cu_rstN`=0, `cu_b`=0, `acc`=0, state IDLE.
- Reset mid-RUN aborts immediately. No `product_valid` is produced and `product` is cleared to 0.
- Latency: `start` sampled at edge k → N RUN cycles → `product_valid` high during the cycle after edge k+N, and `ready` high in that same cycle.
  - B=0: N=1.
  - B=1111: N=2.
  - B=1000: N=2.
  - B=0110: N=3.
  - B=0101: N=5.
  - Maximum N=5.
- Back-to-back: `start` may be asserted in the `product_valid` cycle and is accepted.
- `cu_rstN` is registered and therefore glitch-free. The control unit is out of reset exactly for RUN cycles, so its first-cycle flag is set on the first RUN cycle (forces `op`=0).
- Control inputs are combinational from `cu_b` and control state. They are sampled only in RUN and ignored in IDLE.

## Test plan
- Reset mid-RUN: `start` with A=15, B=5; drop `rstN` in the 2nd RUN cycle → `product`=0, `product_valid`=0, `ready`=1, `cu_rstN`=0 during and after reset; no pulse later.
- A=9, B=0 → one RUN cycle, `product`=0x00, `product_valid` pulse 2 cycles after `start`.
- A=15, B=15 → acc −15 then +240 (full-window rule), `product`=0xE1 (225), N=2.
- A=7, B=5 → acc sequence −7, +7, −21, +35, then terminate-empty; `product`=0x23, N=5.
- A=13, B=8 → −104 then +208, `product`=0x68, N=2; `start` asserted during RUN is ignored.
- Back-to-back: A=3,B=6 then `start` in the `product_valid` cycle with A=0,B=15 → `product`=0x12, then 0x00, two separate one-cycle pulses.
